mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  CPU-side initiator for the word-wide data memory. Accepts one load/store request at a time
//  from the execute stage and drives the memory's read/write strobes, word address and write data.
//  Implements byte/halfword loads (sign/zero-extend) and sub-word stores (read-modify-write).
//  Misaligned accesses are trapped before any memory strobe is raised.
// PARAMETERS
//  ADDR_W      14  word-address width driven to memory (mem_addr = req_addr[ADDR_W+1:2])
//  RD_LATENCY  1   cycles from address presented to mem_rdata valid (legal 1..3)
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  req_valid    in   1       request present
//  req_ready    out  1       unit idle, request accepted when req_valid & req_ready
//  req_we       in   1       1 = store, 0 = load
//  req_size     in   2       00 byte, 01 half, 10 word (11 treated as word)
//  req_unsigned in   1       loads: 1 zero-extend, 0 sign-extend
//  req_addr     in   32      byte address
//  req_wdata    in   32      store data (low bits used for sub-word)
//  resp_valid   out  1       one-cycle pulse, request complete
//  resp_rdata   out  32      load result (0 for stores/errors), valid with resp_valid
//  resp_err     out  1       misaligned access, valid with resp_valid
//  mem_read     out  1       memory read strobe
//  mem_write    out  1       memory write strobe
//  mem_addr     out  ADDR_W  memory word address
//  mem_wdata    out  32      memory write data; 0 whenever mem_write=0
//  mem_rdata    in   32      memory read data
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; resp_valid, resp_err, mem_read, mem_write=0; resp_rdata,
//   mem_addr, mem_wdata=0; latched request cleared. Reset mid-operation aborts it, no write issued.
//  All outputs registered. req_ready=1 only in IDLE; requests while busy ignored (not queued).
//  Request fields latched on accept edge; later input changes have no effect.
//  Misaligned: half with addr[0]=1, word with addr[1:0]!=0 -> IDLE->RESP, resp_err=1, rdata=0,
//   no mem_read/mem_write ever asserted.
//  FSM: IDLE, RD, WAIT, WR, RESP.
//   IDLE -> RD (load, or byte/half store) | WR (word store) | RESP (misaligned).
//   RD: mem_read=1, mem_addr set, 1 cycle. WAIT: mem_read held 1, addr held, RD_LATENCY cycles
//    (down-counter); mem_rdata sampled on last WAIT edge. WAIT -> RESP (load) | WR (store).
//   WR: mem_write=1 for exactly 1 cycle, mem_wdata = full word or merged word. WR -> RESP.
//   RESP: resp_valid=1 one cycle, then IDLE (req_ready=1 next cycle). No back-pressure.
//  Latency (accept cycle = 0): load resp at 2+RD_LATENCY; sub-word store 3+RD_LATENCY;
//   word store 2; misaligned 1.
//  Little-endian lanes: byte k = bits[8k+7:8k], k=addr[1:0]; half at addr[1] -> [15:0]|[31:16].
//  Load extract: lane data, extend per req_unsigned; word load ignores req_unsigned.
//  Store merge: old word with selected lane(s) replaced by req_wdata[7:0] / [15:0]; others unchanged.
//  mem_read and mem_write never high in the same cycle.
// TESTING
//  1 SW 0x11223344 @0x40 -> WR at cycle 1, mem_addr=0x10; LW @0x40 -> resp_rdata=0x11223344 cycle 3.
//  2 SB wdata=0xAA @0x41 over 0x11223344 -> one mem_write, mem_wdata=0x1122AA44; resp cycle 4.
//  3 Word 0x000080F0 @0x0: LB @0x1 -> 0xFFFFFF80; LBU @0x1 -> 0x00000080; LH @0x0 -> 0xFFFF80F0.
//  4 LH @0x3 and SW @0x2 -> resp_err=1 at cycle 1, rdata 0, mem_read/mem_write stay 0.
//  5 rst_n low during WAIT of sub-word store -> outputs 0 at once, no write issued, req_ready=1 after.
//  6 req_valid held during busy + RD_LATENCY=3 -> second request accepted only after RESP; load resp cycle 5.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-wide data memory: sub-word loads with extension,
// sub-word stores by read-modify-write, misaligned requests trapped before any strobe.
module mem_access_unit #(
    parameter int ADDR_W     = 14,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    // state  | meaning
    // IDLE   | ready for a request
    // RD     | read strobe and word address presented
    // WAIT   | read held, counting down the memory read latency
    // WR     | single write strobe, full or merged word
    // RESP   | one-cycle response pulse
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_RESP} state_t;

    localparam logic [1:0] WAIT_LOAD = 2'(RD_LATENCY - 1);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              ready_q, ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              misaligned;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       load_val;
    logic [31:0]       merged;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));

    always_comb begin
        lane_b   = mem_rdata[{off_q, 3'b000} +: 8];
        lane_h   = mem_rdata[{off_q[1], 4'b0000} +: 16];
        load_val = mem_rdata;
        if (size_q == 2'b00) begin
            load_val = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
        end else if (size_q == 2'b01) begin
            load_val = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
        end
        // Sub-word store: replace only the addressed lane(s) of the word just read
        merged = mem_rdata;
        if (size_q == 2'b00) begin
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end else if (size_q == 2'b01) begin
            merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        ready_d      = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_wdata_d  = 32'h0;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (req_valid) begin
                    ready_d = 1'b0;
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata;
                    if (misaligned) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_we && req_size[1]) begin
                        state_d     = S_WR;
                        mem_write_d = 1'b1;
                        mem_wdata_d = req_wdata;
                        mem_addr_d  = req_addr[ADDR_W+1:2];
                    end else begin
                        state_d    = S_RD;
                        mem_read_d = 1'b1;
                        mem_addr_d = req_addr[ADDR_W+1:2];
                    end
                end
            end
            S_RD: begin
                state_d    = S_WAIT;
                mem_read_d = 1'b1;
                cnt_d      = WAIT_LOAD;
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    if (we_q) begin
                        state_d     = S_WR;
                        mem_write_d = 1'b1;
                        mem_wdata_d = merged;
                    end else begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = load_val;
                    end
                end else begin
                    mem_read_d = 1'b1;
                    cnt_d      = cnt_q - 2'd1;
                end
            end
            S_WR: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
            end
            S_RESP: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            wdata_q      <= 32'h0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
